// File: rtl/memory_writer_pkg.sv
// Shared definitions for the pattern-memory writer and reader blocks.
package memory_writer_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } wr_state_t;

endpackage

// File: rtl/key_press_detect.sv
// Raw push-button to single-cycle press pulse: 2-FF synchronizer, optional
// debouncer (MEMORY_WRITER_DEBOUNCE_EN) and falling-edge detector.
module key_press_detect #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_level_d;
  logic r_press;
  logic w_level;

  // Released buttons read high, so reset to 1 to avoid a phantom press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MEMORY_WRITER_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [CNT_W-1:0] r_db_cnt;
  logic             r_db_level;

  // The debounced level follows only after the new level held for DEBOUNCE_CYCLES clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b1;
    end else if (r_sync2 == r_db_level) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db_cnt   <= '0;
      r_db_level <= r_sync2;
    end else begin
      r_db_cnt <= r_db_cnt + CNT_W'(1);
    end
  end

  assign w_level = r_db_level;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (DEBOUNCE_CYCLES == 0);
  assign w_level      = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_d <= 1'b1;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= w_level;
      r_press   <= r_level_d & ~w_level;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/memory_pattern_writer.sv
// Writer side of the running-light pattern RAM: stores SW patterns on key
// presses, sweeps the RAM to zero on clear. Debounce via MEMORY_WRITER_DEBOUNCE_EN.
module memory_pattern_writer
  import memory_writer_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_key_n,
  input  logic              clr_key_n,
  input  logic [DATA_W-1:0] pattern_i,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] addr_end_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              reader_hold_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic w_wr_press;
  logic w_clr_press;

  key_press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (wr_key_n),
    .o_press (w_wr_press)
  );

  key_press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (clr_key_n),
    .o_press (w_clr_press)
  );

  wr_state_t         r_state,     w_state_next;
  logic [ADDR_W-1:0] r_wr_ptr,    w_wr_ptr_next;
  logic [ADDR_W-1:0] r_clr_cnt,   w_clr_cnt_next;
  logic [ADDR_W-1:0] r_addr_end,  w_addr_end_next;
  logic              r_empty,     w_empty_next;
  logic              r_full,      w_full_next;
  logic              r_wr_en,     w_wr_en_next;
  logic [ADDR_W-1:0] r_addr,      w_addr_next;
  logic [DATA_W-1:0] r_data,      w_data_next;
  logic              r_hold,      w_hold_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_clr_cnt  <= '0;
      r_addr_end <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_hold     <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_wr_ptr   <= w_wr_ptr_next;
      r_clr_cnt  <= w_clr_cnt_next;
      r_addr_end <= w_addr_end_next;
      r_empty    <= w_empty_next;
      r_full     <= w_full_next;
      r_wr_en    <= w_wr_en_next;
      r_addr     <= w_addr_next;
      r_data     <= w_data_next;
      r_hold     <= w_hold_next;
    end
  end

  // RAM-port values are computed for the state being entered, so the bus is
  // registered and valid during the WRITE/CLEAR cycle itself.
  always_comb begin
    w_state_next    = r_state;
    w_wr_ptr_next   = r_wr_ptr;
    w_clr_cnt_next  = r_clr_cnt;
    w_addr_end_next = r_addr_end;
    w_empty_next    = r_empty;
    w_full_next     = r_full;
    w_wr_en_next    = 1'b0;
    w_addr_next     = '0;
    w_data_next     = '0;

    case (r_state)
      IDLE: begin
        if (w_clr_press) begin
          w_state_next   = CLEAR;
          w_clr_cnt_next = '0;
          w_wr_en_next   = 1'b1;
        end else if (w_wr_press && !r_full) begin
          w_state_next = WRITE;
          w_wr_en_next = 1'b1;
          w_addr_next  = r_wr_ptr;
          w_data_next  = pattern_i;
        end
      end
      WRITE: begin
        w_state_next    = IDLE;
        w_addr_end_next = r_wr_ptr;
        w_empty_next    = 1'b0;
        if (r_wr_ptr == LAST_ADDR) begin
          w_full_next = 1'b1;
        end else begin
          w_wr_ptr_next = r_wr_ptr + ADDR_W'(1);
        end
      end
      CLEAR: begin
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_next    = IDLE;
          w_clr_cnt_next  = '0;
          w_wr_ptr_next   = '0;
          w_addr_end_next = '0;
          w_empty_next    = 1'b1;
          w_full_next     = 1'b0;
        end else begin
          w_clr_cnt_next = r_clr_cnt + ADDR_W'(1);
          w_wr_en_next   = 1'b1;
          w_addr_next    = w_clr_cnt_next;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    w_hold_next = (w_state_next == WRITE) || (w_state_next == CLEAR) || w_empty_next;
  end

  assign mem_wr_en_o   = r_wr_en;
  assign mem_addr_o    = r_addr;
  assign mem_data_o    = r_data;
  assign addr_end_o    = r_addr_end;
  assign empty_o       = r_empty;
  assign full_o        = r_full;
  assign reader_hold_o = r_hold;

endmodule

// File: tb/tb_memory_pattern_writer.sv
// Directed bench for memory_pattern_writer with a RAM-write scoreboard.
module tb_memory_pattern_writer;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_key_n = 1'b1;
  logic              clr_key_n = 1'b1;
  logic [DATA_W-1:0] pattern_i = '0;
  logic              mem_wr_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] addr_end_o;
  logic              empty_o;
  logic              full_o;
  logic              reader_hold_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t sb[$];

  memory_pattern_writer #(
    .ADDR_W          (ADDR_W),
    .DATA_W          (DATA_W),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_key_n      (wr_key_n),
    .clr_key_n     (clr_key_n),
    .pattern_i     (pattern_i),
    .mem_wr_en_o   (mem_wr_en_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .addr_end_o    (addr_end_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .reader_hold_o (reader_hold_o)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every observed RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && mem_wr_en_o) begin
      wr_t e;
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_write observed addr=%0h data=%0h expected none", mem_addr_o, mem_data_o);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wr_addr", 32'(mem_addr_o), 32'(e.addr));
        check("wr_data", 32'(mem_data_o), 32'(e.data));
        $display("write addr=%0d data=%03h", mem_addr_o, mem_data_o);
      end
    end
  end

  task automatic press_wr(input logic [DATA_W-1:0] pat, input logic [ADDR_W-1:0] addr, input bit expect_write);
    wr_t e;
    pattern_i = pat;
    if (expect_write) begin
      e.addr = addr;
      e.data = pat;
      sb.push_back(e);
    end
    wr_key_n = 1'b0;
    repeat (3) @(negedge clk);
    check("wr_latency_early", 32'(mem_wr_en_o), 32'd0);
    @(negedge clk);
    check("wr_latency", 32'(mem_wr_en_o), 32'(expect_write));
    wr_key_n = 1'b1;
    @(negedge clk);
    check("wr_one_cycle", 32'(mem_wr_en_o), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic push_clear();
    wr_t e;
    for (int i = 0; i < DEPTH; i++) begin
      e.addr = ADDR_W'(i);
      e.data = '0;
      sb.push_back(e);
    end
  endtask

  task automatic clear_sweep(input bit both_keys);
    push_clear();
    clr_key_n = 1'b0;
    if (both_keys) wr_key_n = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_start", 32'(mem_wr_en_o), 32'd1);
    clr_key_n = 1'b1;
    wr_key_n  = 1'b1;
    repeat (DEPTH - 1) @(negedge clk);
    check("clr_last_write", 32'(mem_wr_en_o), 32'd1);
    check("clr_hold_busy", 32'(reader_hold_o), 32'd1);
    @(negedge clk);
    check("clr_done_wr_en", 32'(mem_wr_en_o), 32'd0);
    check("clr_done_empty", 32'(empty_o), 32'd1);
    check("clr_done_full", 32'(full_o), 32'd0);
    check("clr_done_addr_end", 32'(addr_end_o), 32'd0);
    check("clr_sb_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(mem_wr_en_o), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
    check({tag, "_data"}, 32'(mem_data_o), 32'd0);
    check({tag, "_addr_end"}, 32'(addr_end_o), 32'd0);
    check({tag, "_empty"}, 32'(empty_o), 32'd1);
    check({tag, "_full"}, 32'(full_o), 32'd0);
    check({tag, "_hold"}, 32'(reader_hold_o), 32'd1);
  endtask

  initial begin
    // Reset
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("post_reset_idle");

    // Two writes
    press_wr(10'h001, 5'd0, 1'b1);
    press_wr(10'h002, 5'd1, 1'b1);
    check("two_addr_end", 32'(addr_end_o), 32'd1);
    check("two_empty", 32'(empty_o), 32'd0);
    check("two_hold", 32'(reader_hold_o), 32'd0);
    check("two_idle_addr", 32'(mem_addr_o), 32'd0);

    // Three more writes, then clear; next write lands at address 0
    for (int i = 2; i < 5; i++) press_wr(DATA_W'(i + 1), ADDR_W'(i), 1'b1);
    check("five_addr_end", 32'(addr_end_o), 32'd4);
    clear_sweep(1'b0);
    check("clr_hold_empty", 32'(reader_hold_o), 32'd1);

    // Fill to full: 33 presses, pattern = press index
    for (int i = 0; i <= DEPTH; i++) begin
      press_wr(DATA_W'(i), ADDR_W'(i), i < DEPTH);
      if (i == DEPTH - 2) check("not_full_yet", 32'(full_o), 32'd0);
    end
    check("full_flag", 32'(full_o), 32'd1);
    check("full_addr_end", 32'(addr_end_o), 32'd31);
    check("full_hold", 32'(reader_hold_o), 32'd0);

    // Simultaneous press: clear wins
    clear_sweep(1'b1);
    press_wr(10'h155, 5'd0, 1'b1);
    check("after_sim_addr_end", 32'(addr_end_o), 32'd0);
    check("after_sim_empty", 32'(empty_o), 32'd0);

    // Reset at clear cycle 10
    push_clear();
    clr_key_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rclr_start", 32'(mem_wr_en_o), 32'd1);
    clr_key_n = 1'b1;
    repeat (9) @(negedge clk);
    check("rclr_cycle10_addr", 32'(mem_addr_o), 32'd9);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("mid_clear_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("after_mid_clear");
    press_wr(10'h2AA, 5'd0, 1'b1);
    check("after_rst_addr_end", 32'(addr_end_o), 32'd0);
    check("after_rst_empty", 32'(empty_o), 32'd0);

    repeat (5) @(negedge clk);
    check("sb_empty_at_end", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
